mips_pipe_ctrl: RTL and testbench

- Parametrised pipeline control unit for the synthesizable MIPS-subset core.
- Keeps a scoreboard of in-flight instructions from E to the last stage, detects RAW hazards, and drives decode stall and flush.
- Handles HALT drain.
- Keeps saturating hardware statistics counters, in the same categories as the simulator's stats record.
- Sits beside the decode stage; the stage count and the forwarding mode are configurable.

---
 rtl/mips_pipe_ctrl_pkg.sv | 63 ++++++
 rtl/mips_sat_counter.sv | 20 ++
 rtl/mips_pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_ctrl_pkg.sv
// Shared types for the MIPS-subset pipeline control unit.
// Provides the opcode enum, the instruction class enum, the scoreboard
// entry layout and the opcode-to-class mapping.
package mips_pipe_ctrl_pkg;

  localparam int unsigned OPC_W  = 6;  // opcode encoding width
  localparam int unsigned DEST_W = 8;  // scoreboard dest field, fits any legal REG_W

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 6'h00,
    OP_ADDI = 6'h01,
    OP_SUB  = 6'h02,
    OP_SUBI = 6'h03,
    OP_MUL  = 6'h04,
    OP_MULI = 6'h05,
    OP_OR   = 6'h06,
    OP_ORI  = 6'h07,
    OP_AND  = 6'h08,
    OP_ANDI = 6'h09,
    OP_XOR  = 6'h0A,
    OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C,
    OP_STW  = 6'h0D,
    OP_BZ   = 6'h0E,
    OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10,
    OP_HALT = 6'h11,
    OP_NOP  = 6'h12
  } operation_t;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ARITH = 3'd1,
    CLS_LOG   = 3'd2,
    CLS_MEM   = 3'd3,
    CLS_CTRL  = 3'd4
  } op_class_t;

  // One in-flight instruction between E and W.
  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [DEST_W-1:0] dest;
    logic              is_load;
    logic              is_halt;  // marks the HALT so retirement can stop the core
    op_class_t         cls;
  } sb_entry_t;

  // Statistics class of an opcode; NOP and unknown opcodes have no class.
  function automatic op_class_t op_class(input operation_t op);
    op_class_t c;
    c = CLS_NONE;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI: c = CLS_ARITH;
      OP_OR, OP_ORI, OP_AND, OP_ANDI, OP_XOR, OP_XORI:   c = CLS_LOG;
      OP_LDW, OP_STW:                                    c = CLS_MEM;
      OP_BZ, OP_BEQ, OP_JR, OP_HALT:                     c = CLS_CTRL;
      default:                                           c = CLS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating statistics counter: counts inc pulses, sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc (count enable), count (value).
module mips_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline control unit for the MIPS-subset core.
// Tracks in-flight instructions in slots E..W, detects RAW hazards against
// the instruction in D, drives stall/flush, drains on HALT and keeps
// saturating statistics counters.
// Ports: clk, rst_n; D-stage instruction (id_*); ex_redirect from E;
// stall/flush to F and D (combinational); stage_valid, halted and
// cnt_* statistics (registered).
module mips_pipe_ctrl
  import mips_pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES  = 5,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned FORWARD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_wr_en,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush,
  output logic [STAGES-3:0] stage_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  cnt_inst,
  output logic [CNT_W-1:0]  cnt_arith,
  output logic [CNT_W-1:0]  cnt_log,
  output logic [CNT_W-1:0]  cnt_mem,
  output logic [CNT_W-1:0]  cnt_ctrl,
  output logic [CNT_W-1:0]  cnt_stalls,
  output logic [CNT_W-1:0]  cnt_hazards,
  output logic [CNT_W-1:0]  cnt_mispredicts
);

  localparam int unsigned NSLOT = STAGES - 2;

  sb_entry_t  slot_q [NSLOT];
  logic       halt_pend_q;
  logic       halted_q;
  logic       hz_prev_q;
  operation_t id_op;
  sb_entry_t  id_entry;
  logic       hazard;
  logic       hold;
  logic       issue;
  logic       hz_stall;
  logic       retire_v;
  logic [7:0] inc;

  assign id_op = operation_t'(OPC_W'(id_opcode));

  // RAW check: without bypass every pending writer except W (write-first
  // register file) blocks; with bypass only a load sitting in E does.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      if (slot_q[i].valid && slot_q[i].wr_en && (slot_q[i].dest != '0) &&
          ((slot_q[i].dest == DEST_W'(id_rs)) ||
           (id_uses_rt && (slot_q[i].dest == DEST_W'(id_rt))))) begin
        if (FORWARD != 0) begin
          if ((i == 0) && slot_q[i].is_load) hazard = 1'b1;
        end else if (i < int'(NSLOT) - 1) begin
          hazard = 1'b1;
        end
      end
    end
    hazard = hazard & id_valid;
  end

  // Redirect wins over any stall; both forced low while reset is held.
  assign hold     = halt_pend_q | halted_q;
  assign stall    = rst_n & (hazard | hold) & ~ex_redirect;
  assign flush    = rst_n & ex_redirect;
  assign issue    = id_valid & ~stall & ~flush & ~hold;
  assign hz_stall = hazard & ~ex_redirect & ~hold;
  assign retire_v = slot_q[NSLOT-1].valid & ~halted_q;

  // Entry for slot E: the issued instruction or a bubble.
  always_comb begin
    id_entry = '0;
    if (issue) begin
      id_entry.valid   = 1'b1;
      id_entry.wr_en   = id_wr_en;
      id_entry.dest    = DEST_W'(id_rd);
      id_entry.is_load = (id_op == OP_LDW);
      id_entry.is_halt = (id_op == OP_HALT);
      id_entry.cls     = op_class(id_op);
    end
  end

  // Scoreboard shift, HALT drain and hazard-episode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NSLOT); i++) slot_q[i] <= '0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      hz_prev_q   <= 1'b0;
    end else begin
      slot_q[0] <= id_entry;
      for (int i = 1; i < int'(NSLOT); i++) slot_q[i] <= slot_q[i-1];
      hz_prev_q <= hz_stall;
      if (slot_q[NSLOT-1].valid && slot_q[NSLOT-1].is_halt) begin
        halted_q    <= 1'b1;
        halt_pend_q <= 1'b0;
      end else if (issue && id_entry.is_halt) begin
        halt_pend_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NSLOT); i++) stage_valid[i] = slot_q[i].valid;
  end

  assign halted = halted_q;

  // Counter enables; everything freezes once the core has halted.
  always_comb begin
    inc = '0;
    if (!halted_q) begin
      inc[0] = retire_v;
      inc[1] = retire_v && (slot_q[NSLOT-1].cls == CLS_ARITH);
      inc[2] = retire_v && (slot_q[NSLOT-1].cls == CLS_LOG);
      inc[3] = retire_v && (slot_q[NSLOT-1].cls == CLS_MEM);
      inc[4] = retire_v && (slot_q[NSLOT-1].cls == CLS_CTRL);
      inc[5] = hz_stall;
      inc[6] = hz_stall & ~hz_prev_q;
      inc[7] = ex_redirect;
    end
  end

  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_inst (.clk(clk), .rst_n(rst_n), .inc(inc[0]), .count(cnt_inst));
  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_arith (.clk(clk), .rst_n(rst_n), .inc(inc[1]), .count(cnt_arith));
  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_log (.clk(clk), .rst_n(rst_n), .inc(inc[2]), .count(cnt_log));
  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_mem (.clk(clk), .rst_n(rst_n), .inc(inc[3]), .count(cnt_mem));
  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_ctrl (.clk(clk), .rst_n(rst_n), .inc(inc[4]), .count(cnt_ctrl));
  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_stalls (.clk(clk), .rst_n(rst_n), .inc(inc[5]), .count(cnt_stalls));
  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_hazards (.clk(clk), .rst_n(rst_n), .inc(inc[6]), .count(cnt_hazards));
  mips_sat_counter #(.CNT_W(CNT_W)) u_cnt_mispredicts (.clk(clk), .rst_n(rst_n), .inc(inc[7]), .count(cnt_mispredicts));

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Bench for mips_pipe_ctrl: three configurations share one input stream
// (no bypass / 5 stages, full bypass / 5 stages, no bypass / 7 stages with
// 4-bit counters) and each is checked every cycle against a model that
// tracks issued instructions by issue cycle.
module tb_mips_pipe_ctrl;
  import mips_pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rt, id_wr_en, ex_redirect;

  logic        stall_o [3];
  logic        flush_o [3];
  logic        halted_o [3];
  logic [2:0]  sv0, sv1;
  logic [4:0]  sv2;
  logic [31:0] c0 [8];
  logic [31:0] c1 [8];
  logic [3:0]  c2 [8];

  int ncmp;
  int nfail;

  always #5 clk = ~clk;

  mips_pipe_ctrl #(.STAGES(5), .REG_W(5), .OP_W(6), .CNT_W(32), .FORWARD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .ex_redirect(ex_redirect), .stall(stall_o[0]), .flush(flush_o[0]), .stage_valid(sv0),
    .halted(halted_o[0]), .cnt_inst(c0[0]), .cnt_arith(c0[1]), .cnt_log(c0[2]), .cnt_mem(c0[3]),
    .cnt_ctrl(c0[4]), .cnt_stalls(c0[5]), .cnt_hazards(c0[6]), .cnt_mispredicts(c0[7]));

  mips_pipe_ctrl #(.STAGES(5), .REG_W(5), .OP_W(6), .CNT_W(32), .FORWARD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .ex_redirect(ex_redirect), .stall(stall_o[1]), .flush(flush_o[1]), .stage_valid(sv1),
    .halted(halted_o[1]), .cnt_inst(c1[0]), .cnt_arith(c1[1]), .cnt_log(c1[2]), .cnt_mem(c1[3]),
    .cnt_ctrl(c1[4]), .cnt_stalls(c1[5]), .cnt_hazards(c1[6]), .cnt_mispredicts(c1[7]));

  mips_pipe_ctrl #(.STAGES(7), .REG_W(5), .OP_W(6), .CNT_W(4), .FORWARD(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .ex_redirect(ex_redirect), .stall(stall_o[2]), .flush(flush_o[2]), .stage_valid(sv2),
    .halted(halted_o[2]), .cnt_inst(c2[0]), .cnt_arith(c2[1]), .cnt_log(c2[2]), .cnt_mem(c2[3]),
    .cnt_ctrl(c2[4]), .cnt_stalls(c2[5]), .cnt_hazards(c2[6]), .cnt_mispredicts(c2[7]));

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       v;
    bit       wr;
    bit [7:0] dest;
    bit       ld;
    bit       hlt;
    bit [2:0] cls;
  } rec_t;

  int     mslots [3] = '{3, 3, 5};
  int     mfwd   [3] = '{0, 1, 0};
  longint mmax   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  rec_t   hist [3][16];  // what each model issued, indexed by cycle number
  int     cyc;
  bit     m_hp [3];
  bit     m_halted [3];
  bit     m_hzp [3];
  bit     m_iss [3];
  longint m_cnt [3][8];

  function automatic int tb_cls(int op);
    if (op >= int'(OP_ADD) && op <= int'(OP_MULI)) return 1;
    if (op >= int'(OP_OR) && op <= int'(OP_XORI)) return 2;
    if (op == int'(OP_LDW) || op == int'(OP_STW)) return 3;
    if (op >= int'(OP_BZ) && op <= int'(OP_HALT)) return 4;
    return 0;
  endfunction

  // Instruction occupying slot k (0 = E): the one issued k+1 cycles ago.
  function automatic rec_t slot(int m, int k);
    int t;
    t = cyc - 1 - k;
    if (t < 0) return '0;
    return hist[m][t % 16];
  endfunction

  function automatic bit m_hazard(int m);
    bit   h;
    int   lim;
    rec_t e;
    h = 1'b0;
    lim = (mfwd[m] != 0) ? 1 : mslots[m] - 1;
    for (int k = 0; k < lim; k++) begin
      e = slot(m, k);
      if (e.v && e.wr && e.dest != 8'd0 && (mfwd[m] == 0 || e.ld) &&
          (e.dest == 8'(id_rs) || (id_uses_rt && e.dest == 8'(id_rt))))
        h = 1'b1;
    end
    return h && id_valid;
  endfunction

  function automatic bit m_stall(int m);
    return (m_hazard(m) || m_hp[m] || m_halted[m]) && !ex_redirect;
  endfunction

  task automatic m_reset();
    cyc = 0;
    for (int m = 0; m < 3; m++) begin
      for (int j = 0; j < 16; j++) hist[m][j] = '0;
      for (int i = 0; i < 8; i++) m_cnt[m][i] = 0;
      m_hp[m] = 0; m_halted[m] = 0; m_hzp[m] = 0; m_iss[m] = 0;
    end
  endtask

  task automatic m_inc(int m, int i);
    if (m_cnt[m][i] < mmax[m]) m_cnt[m][i] = m_cnt[m][i] + 1;
  endtask

  // Model state update for the clock edge ending the current cycle.
  task automatic adv_all();
    bit   hz, hzs, iss, hold;
    rec_t lv, nr;
    for (int m = 0; m < 3; m++) begin
      hz   = m_hazard(m);
      hold = m_hp[m] || m_halted[m];
      iss  = id_valid && !m_stall(m) && !ex_redirect && !hold;
      hzs  = hz && !ex_redirect && !hold;
      lv   = slot(m, mslots[m] - 1);
      if (!m_halted[m]) begin
        if (lv.v) begin
          m_inc(m, 0);
          if (lv.cls != 0) m_inc(m, int'(lv.cls));
        end
        if (hzs) m_inc(m, 5);
        if (hzs && !m_hzp[m]) m_inc(m, 6);
        if (ex_redirect) m_inc(m, 7);
      end
      m_hzp[m] = hzs;
      nr = '0;
      if (iss) begin
        nr.v = 1; nr.wr = id_wr_en; nr.dest = 8'(id_rd);
        nr.ld = (id_opcode == OP_LDW); nr.hlt = (id_opcode == OP_HALT);
        nr.cls = 3'(tb_cls(int'(id_opcode)));
      end
      hist[m][cyc % 16] = nr;
      m_iss[m] = iss;
      if (lv.v && lv.hlt) begin
        m_halted[m] = 1; m_hp[m] = 0;
      end else if (iss && nr.hlt) begin
        m_hp[m] = 1;
      end
    end
    cyc++;
  endtask

  // ---------------- DUT access and checking ----------------
  function automatic longint get_cnt(int m, int i);
    case (m)
      0:       return longint'(c0[i]);
      1:       return longint'(c1[i]);
      default: return longint'(c2[i]);
    endcase
  endfunction

  function automatic int get_sv(int m);
    case (m)
      0:       return int'(sv0);
      1:       return int'(sv1);
      default: return int'(sv2);
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit   es, ef;
    int   esv;
    rec_t e;
    for (int m = 0; m < 3; m++) begin
      es = rst_n ? m_stall(m) : 1'b0;
      ef = rst_n ? ex_redirect : 1'b0;
      esv = 0;
      for (int k = 0; k < mslots[m]; k++) begin
        e = slot(m, k);
        if (e.v) esv = esv | (1 << k);
      end
      chk($sformatf("m%0d_stall@%0d", m, cyc), longint'(stall_o[m]), longint'(es));
      chk($sformatf("m%0d_flush@%0d", m, cyc), longint'(flush_o[m]), longint'(ef));
      chk($sformatf("m%0d_stage_valid@%0d", m, cyc), longint'(get_sv(m)), longint'(esv));
      chk($sformatf("m%0d_halted@%0d", m, cyc), longint'(halted_o[m]), longint'(m_halted[m]));
      for (int i = 0; i < 8; i++)
        chk($sformatf("m%0d_cnt%0d@%0d", m, i, cyc), get_cnt(m, i), m_cnt[m][i]);
    end
  endtask

  task automatic cyc1();
    @(negedge clk);
    check_all();
    adv_all();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("m%0d_rst_stall", m), longint'(stall_o[m]), 0);
      chk($sformatf("m%0d_rst_flush", m), longint'(flush_o[m]), 0);
      chk($sformatf("m%0d_rst_sv", m), longint'(get_sv(m)), 0);
      chk($sformatf("m%0d_rst_stalls", m), get_cnt(m, 5), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present one instruction in D until model tgt issues it.
  task automatic send(input operation_t op, input int rd, input int rs, input int rt,
                      input bit ur, input bit wr, input int tgt, output int nst);
    id_valid = 1'b1; id_opcode = op; id_rd = 5'(rd); id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rt = ur; id_wr_en = wr;
    nst = 0;
    for (int g = 0; g < 40; g++) begin
      cyc1();
      if (m_iss[tgt]) break;
      nst++;
    end
    ncmp++;
    assert (m_iss[tgt]) else begin
      nfail++;
      $error("FAIL issue_timeout op=%0d target=%0d waited=%0d", int'(op), tgt, nst);
    end
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    repeat (n) cyc1();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    int tot;
    int prev;
    int d;
    int v;
    ncmp = 0; nfail = 0;
    rst_n = 1'b1; id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rt = 0; id_wr_en = 0; ex_redirect = 0;
    m_reset();
    @(posedge clk); #1;
    do_reset();

    // No bypass: back-to-back dependent ADDs stall twice.
    send(OP_ADD, 3, 1, 2, 1, 1, 0, ns);
    send(OP_ADD, 4, 3, 1, 1, 1, 0, ns);
    chk("t1_stall_cycles", ns, 2);
    chk("t1_cnt_stalls", get_cnt(0, 5), 2);
    chk("t1_cnt_hazards", get_cnt(0, 6), 1);
    idle(6);

    // Full bypass: load-use stalls once, ALU result does not.
    do_reset();
    send(OP_LDW, 5, 1, 0, 0, 1, 1, ns);
    send(OP_ADD, 6, 5, 0, 1, 1, 1, ns);
    chk("t2_load_use_stalls", ns, 1);
    idle(4);
    send(OP_ADDI, 5, 1, 0, 0, 1, 1, ns);
    send(OP_ADD, 6, 5, 0, 1, 1, 1, ns);
    chk("t2_alu_use_stalls", ns, 0);
    idle(4);

    // r0 never hazards; rt ignored when not read.
    do_reset();
    send(OP_ADDI, 0, 1, 0, 0, 1, 0, ns);
    send(OP_ADD, 1, 0, 0, 1, 1, 0, ns);
    chk("t3_r0_stalls", ns, 0);
    send(OP_ADDI, 7, 2, 0, 0, 1, 0, ns);
    send(OP_STW, 0, 2, 7, 0, 0, 0, ns);
    chk("t3_rt_unused_stalls", ns, 0);
    idle(6);

    // Redirect during a hazard stall.
    do_reset();
    send(OP_ADD, 3, 1, 2, 1, 1, 0, ns);
    id_valid = 1; id_opcode = OP_ADD; id_rd = 4; id_rs = 3; id_rt = 1; id_uses_rt = 1; id_wr_en = 1;
    #1;
    chk("t4_stall_before", longint'(stall_o[0]), 1);
    cyc1();
    ex_redirect = 1'b1;
    #1;
    chk("t4_stall_redirect", longint'(stall_o[0]), 0);
    chk("t4_flush_redirect", longint'(flush_o[0]), 1);
    cyc1();
    ex_redirect = 1'b0;
    chk("t4_mispredicts", get_cnt(0, 7), 1);
    chk("t4_stalls_unchanged", get_cnt(0, 5), 1);
    chk("t4_bubble_in_e", longint'(sv0[0]), 0);
    idle(6);

    // HALT drain with one instruction of each class plus NOP.
    do_reset();
    send(OP_ADD, 1, 2, 3, 1, 1, 0, ns);
    send(OP_ORI, 4, 5, 0, 0, 1, 0, ns);
    send(OP_LDW, 6, 7, 0, 0, 1, 0, ns);
    send(OP_BZ, 0, 1, 0, 0, 0, 0, ns);
    send(OP_NOP, 0, 0, 0, 0, 0, 0, ns);
    send(OP_HALT, 0, 0, 0, 0, 0, 0, ns);
    id_valid = 1; id_opcode = OP_ADD; id_rd = 2; id_rs = 2; id_rt = 2; id_uses_rt = 1; id_wr_en = 1;
    repeat (12) cyc1();
    chk("t5_halted", longint'(halted_o[0]), 1);
    chk("t5_cnt_inst", get_cnt(0, 0), 6);
    chk("t5_cnt_arith", get_cnt(0, 1), 1);
    chk("t5_cnt_log", get_cnt(0, 2), 1);
    chk("t5_cnt_mem", get_cnt(0, 3), 1);
    chk("t5_cnt_ctrl", get_cnt(0, 4), 2);
    chk("t5_no_issue_after_halt", longint'(sv0), 0);

    // 4-bit counters on the 7-stage instance saturate.
    do_reset();
    prev = 1;
    send(OP_ADD, 1, 2, 2, 1, 1, 2, ns);
    tot = 0;
    for (int j = 0; j < 6; j++) begin
      d = (prev == 1) ? 2 : 1;
      send(OP_ADD, d, prev, 3, 1, 1, 2, ns);
      tot += ns;
      prev = d;
    end
    chk("t6_total_stall_cycles", tot, 24);
    chk("t6_cnt_stalls_sat", get_cnt(2, 5), 15);
    chk("t6_cnt_hazards", get_cnt(2, 6), 6);

    // Reset in the middle of a stalled, redirected stream.
    d = (prev == 1) ? 2 : 1;
    id_valid = 1; id_opcode = OP_ADD; id_rd = 5'(d); id_rs = 5'(prev); id_rt = 0; id_uses_rt = 0;
    id_wr_en = 1; ex_redirect = 1;
    cyc1();
    do_reset();
    ex_redirect = 0;
    id_valid = 1; id_opcode = OP_ADDI; id_rd = 1; id_rs = 2; id_rt = 0; id_uses_rt = 0; id_wr_en = 1;
    cyc1();
    chk("t7_first_issue_m0", longint'(sv0[0]), 1);
    chk("t7_first_issue_m2", longint'(sv2[0]), 1);
    idle(6);

    // Random traffic without HALT, then a HALT to stop every instance.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      v = int'($urandom_range(0, 18));
      if (v == 17) v = 48;
      id_opcode = 6'(v);
      id_rs = 5'($urandom_range(0, 5));
      id_rt = 5'($urandom_range(0, 5));
      id_rd = 5'($urandom_range(0, 5));
      id_uses_rt = 1'($urandom_range(0, 1));
      id_wr_en = ($urandom_range(0, 3) != 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      cyc1();
    end
    ex_redirect = 0;
    id_valid = 1; id_opcode = OP_HALT; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0; id_wr_en = 0;
    repeat (20) cyc1();
    for (int m = 0; m < 3; m++) chk($sformatf("rand_halted_m%0d", m), longint'(halted_o[m]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
